// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported variable-latency memory between fetch and data ports,
// data-first with a fetch anti-starvation limit and a sticky response timeout.
module mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic              gnt_i_q, gnt_i_d, gnt_d_q, gnt_d_d, pick_i;
    logic [SW-1:0]     streak_q, streak_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d, d_ready_q, d_ready_d, err_q, err_d;

    always_comb begin
        state_d     = state_q;
        gnt_i_d     = gnt_i_q;
        gnt_d_d     = gnt_d_q;
        streak_d    = streak_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        pick_i      = if_req && (!d_req || streak_q == SW'(MAX_STREAK));
        case (state_q)
            IDLE: if (if_req || d_req) begin
                state_d     = ISSUE;
                gnt_i_d     = pick_i;
                gnt_d_d     = !pick_i;
                // streak only grows while a fetch is actually waiting behind data
                streak_d    = (pick_i || !if_req) ? '0 : streak_q + 1'b1;
                tcnt_d      = '0;
                mem_req_d   = 1'b1;
                mem_we_d    = !pick_i && d_we;
                mem_addr_d  = pick_i ? if_addr : d_addr;
                mem_wdata_d = pick_i ? '0 : d_wdata;
            end
            ISSUE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (mem_ack || tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    tcnt_d      = '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if_ready_d  = gnt_i_q;
                    d_ready_d   = gnt_d_q;
                    err_d       = err_q || !mem_ack;
                    if (gnt_i_q)
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    else if (!mem_ack || !mem_we_q)
                        d_rdata_d = mem_ack ? mem_rdata : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_i_q     <= 1'b0;
            gnt_d_q     <= 1'b0;
            streak_q    <= '0;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_i_q     <= gnt_i_d;
            gnt_d_q     <= gnt_d_d;
            streak_q    <= streak_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a memory device model
// and a transaction-level arbitration/scoreboard model.
module tb_mem_arbiter;
    localparam int MAXS = 4;

    logic        clk = 1'b0, reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, err;

    int          n_chk = 0, n_fail = 0;
    int          ack_lat = 1, acnt = 0;
    logic        ack_en = 1'b1, late_ack = 1'b0;
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic        got_i, got_d, gi_exp, pend_i, pend_d, f_we;
    int          cyc, nreq, m_streak, r;
    logic [31:0] f_addr, f_wd, exp_if, exp_d;
    logic [9:0]  seq;

    mem_arbiter #(.DATA_W(32), .MAX_STREAK(MAXS), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hval(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : hval(a);
    endfunction

    // memory device: acks after ack_lat request cycles, stores writes
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            acnt++;
            if (ack_en && acnt == ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : hval(mem_addr);
                if (mem_we) dev_mem[mem_addr] = mem_wdata;
            end
        end else begin
            acnt = 0;
            if (late_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int limit, output logic gi, output logic gd, output int c,
                              output int nr, output logic [31:0] fa, output logic fw,
                              output logic [31:0] fd);
        gi = 0; gd = 0; c = 0; nr = 0; fa = '0; fw = 0; fd = '0;
        while (c < limit && !gi && !gd) begin
            @(negedge clk);
            c++;
            if (mem_req) begin
                if (nr == 0) begin
                    fa = mem_addr; fw = mem_we; fd = mem_wdata;
                end
                nr++;
            end
            gi = if_ready;
            gd = d_ready;
        end
        chk("ready_seen", {31'b0, gi | gd}, 32'd1);
    endtask

    task automatic new_fetch();
        pend_i  = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h100 + 4 * $urandom_range(0, 15);
    endtask

    task automatic new_data();
        pend_d  = 1'b1;
        d_req   = 1'b1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 32'h100 + 4 * $urandom_range(0, 15);
        d_wdata = $urandom;
    endtask

    initial begin
        dev_mem[32'h40] = 32'hE3A00005; ref_mem[32'h40] = 32'hE3A00005;
        dev_mem[32'h80] = 32'h12345678; ref_mem[32'h80] = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        chk("rst_ready", {if_ready, d_ready}, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        @(negedge clk);
        // fetch read
        if_req = 1'b1; if_addr = 32'h40; ack_lat = 1;
        wait_ready(20, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
        if_req = 1'b0;
        chk("f_port", {got_i, got_d}, 2'b10);
        chk("f_latency", cyc, 2);
        chk("f_addr", f_addr, 32'h40);
        chk("f_we", f_we, 0);
        chk("f_rdata", if_rdata, 32'hE3A00005);
        chk("f_drdata", d_rdata, 0);
        @(negedge clk);
        chk("f_pulse", {if_ready, d_ready}, 0);
        // data read to give d_rdata a known non-zero value
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; ack_lat = 2;
        wait_ready(20, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
        d_req = 1'b0;
        chk("dr_port", {got_i, got_d}, 2'b01);
        chk("dr_rdata", d_rdata, 32'h12345678);
        chk("dr_ifrdata", if_rdata, 32'hE3A00005);
        @(negedge clk);
        // data write with wait states
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'd7; ack_lat = 3;
        ref_mem[32'h64] = 32'd7;
        wait_ready(20, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
        d_req = 1'b0; d_we = 1'b0;
        chk("w_port", {got_i, got_d}, 2'b01);
        chk("w_req_cycles", nreq, 3);
        chk("w_addr", f_addr, 32'h64);
        chk("w_we", f_we, 1);
        chk("w_wdata", f_wd, 32'd7);
        chk("w_drdata", d_rdata, 32'h12345678);
        @(negedge clk);
        chk("w_pulse", d_ready, 0);
        chk("w_stored", dev_mem.exists(32'h64) ? dev_mem[32'h64] : 32'hFFFFFFFF, 32'd7);
        // starvation limit: both held, immediate acks
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80; ack_lat = 1;
        seq = 10'h210;
        for (int k = 0; k < 10; k++) begin
            wait_ready(20, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
            chk($sformatf("starve_gnt%0d", k), {got_i, got_d}, seq[k] ? 2'b10 : 2'b01);
            if (k == 9) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("starve_pulse%0d", k), {if_ready, d_ready}, 0);
        end
        chk("starve_ifrdata", if_rdata, 32'hE3A00005);
        chk("starve_drdata", d_rdata, 32'h12345678);
        // timeout on a data read
        ack_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
        wait_ready(40, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
        d_req = 1'b0;
        chk("to_port", {got_i, got_d}, 2'b01);
        chk("to_req_cycles", nreq, 15);
        chk("to_rdata", d_rdata, 0);
        chk("to_err", err, 1);
        chk("to_ifrdata", if_rdata, 32'hE3A00005);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", err, 1);
        late_ack = 1'b1;
        repeat (2) @(negedge clk);
        late_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_idle", {mem_req, if_ready, d_ready}, 0);
            chk("late_rdata", d_rdata, 0);
        end
        chk("late_err", err, 1);
        // reset mid-transaction
        if_req = 1'b1; if_addr = 32'h40;
        repeat (5) @(negedge clk);
        chk("mid_in_issue", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("mid_mem_req", mem_req, 0);
        chk("mid_ready", {if_ready, d_ready}, 0);
        chk("mid_err", err, 0);
        chk("mid_rdata", if_rdata | d_rdata, 0);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ack_en = 1'b1; ack_lat = 2;
        if_req = 1'b1; if_addr = 32'h40;
        wait_ready(20, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
        if_req = 1'b0;
        chk("post_port", {got_i, got_d}, 2'b10);
        chk("post_latency", cyc, 3);
        chk("post_rdata", if_rdata, 32'hE3A00005);
        @(negedge clk);
        // ack on the last allowed ISSUE cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; ack_lat = 15;
        wait_ready(40, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
        d_req = 1'b0;
        chk("last_req_cycles", nreq, 15);
        chk("last_rdata", d_rdata, 32'h12345678);
        chk("last_err", err, 0);
        @(negedge clk);
        // randomized traffic against the transaction-level model
        pend_i = 1'b0; pend_d = 1'b0; m_streak = 0;
        exp_if = if_rdata_exp(); exp_d = 32'h12345678;
        for (int k = 0; k < 200; k++) begin
            if (!pend_i && !pend_d) begin
                r = $urandom_range(0, 2);
                if (r != 1) new_fetch();
                if (r != 0) new_data();
            end
            gi_exp = pend_i && (!pend_d || m_streak == MAXS);
            m_streak = (gi_exp || !pend_i) ? 0 : m_streak + 1;
            if (gi_exp) exp_if = ref_rd(if_addr);
            else if (d_we) ref_mem[d_addr] = d_wdata;
            else exp_d = ref_rd(d_addr);
            ack_lat = $urandom_range(1, 4);
            wait_ready(30, got_i, got_d, cyc, nreq, f_addr, f_we, f_wd);
            chk("rnd_port", {got_i, got_d}, gi_exp ? 2'b10 : 2'b01);
            chk("rnd_ifrdata", if_rdata, exp_if);
            chk("rnd_drdata", d_rdata, exp_d);
            if (gi_exp) begin
                pend_i = 1'b0; if_req = 1'b0;
                if ($urandom_range(0, 1) == 1) new_fetch();
                if (!pend_d && $urandom_range(0, 2) == 0) new_data();
            end else begin
                pend_d = 1'b0; d_req = 1'b0;
                if ($urandom_range(0, 1) == 1) new_data();
                if (!pend_i && $urandom_range(0, 2) == 0) new_fetch();
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (25) @(negedge clk);
        chk("end_idle", {mem_req, if_ready, d_ready, err}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    function automatic logic [31:0] if_rdata_exp();
        return 32'hE3A00005;
    endfunction
endmodule
